// File: rtl/serial_out_port_pkg.sv
// Shared definitions for the serial output port and the other W-bus blocks:
// FSM encodings, bus constants and a counter-width helper.
package serial_out_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } sop_state_e;

    localparam int unsigned W_BUS_WIDTH = 8;

    localparam logic [W_BUS_WIDTH-1:0] HIGH_IMPEDANCE = {W_BUS_WIDTH{1'bz}};
    localparam logic [W_BUS_WIDTH-1:0] ZERO_STATE     = {W_BUS_WIDTH{1'b0}};

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_out_port_if.sv
// W-bus load request and serial/status outputs of output port 4.
interface serial_out_port_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] WBUS;
    logic             nLo4;
    logic             SOUT;
    logic             READY;
    logic             DONE;
    logic [WIDTH-1:0] SHREG;

    modport master (output WBUS, nLo4, input SOUT, READY, DONE, SHREG);
    modport slave  (input WBUS, nLo4, output SOUT, READY, DONE, SHREG);
endinterface

// File: rtl/serial_out_port_bit_timer.sv
// Modulo-BIT_CYCLES counter that flags the last clock of each serial bit.
// Held at zero while disabled and cleared whenever the FSM changes state.
module serial_out_port_bit_timer
    import serial_out_port_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic tc_o
);
    localparam int unsigned CW = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // NOTE: a default assignment at the top of every always_comb keeps all
    // paths assigned, so no latch can be inferred.
    always_comb begin
        count_d = count_q;
        if (restart_i || !en_i || count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Must not depend on restart_i: restart is itself derived from this flag.
    assign tc_o = en_i && (count_q == LAST);

endmodule

// File: rtl/serial_out_port.sv
// SAP-II output port 4: captures a W-bus byte on nLo4 and sends it LSB-first
// with a start (0) and stop (1) bit, each bit held for BIT_CYCLES clocks.
module serial_out_port
    import serial_out_port_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 4
) (
    input logic               CLK,
    input logic               nCLR,
    serial_out_port_if.slave  bus
);
    localparam int unsigned BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    sop_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             bit_tc;

    serial_out_port_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_i     (CLK),
        .rst_ni    (nCLR),
        .en_i      (state_q != IDLE),
        .restart_i (state_q != state_d),
        .tc_o      (bit_tc)
    );

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.nLo4) state_d = START;
            START:   if (bit_tc) state_d = DATA;
            DATA:    if (bit_tc && bit_q == LAST_BIT) state_d = STOP;
            STOP:    if (bit_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loads only from IDLE, so W-bus activity during a frame is ignored.
    always_comb begin
        shreg_d = shreg_q;
        bit_d   = bit_q;
        if (state_q == IDLE && state_d == START) begin
            shreg_d = bus.WBUS;
            bit_d   = '0;
        end else if (state_q == DATA && bit_tc) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + BW'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so SOUT changes
    // on the same edge as the state it belongs to.
    always_comb begin
        case (state_d)
            START:   sout_d = 1'b0;
            DATA:    sout_d = shreg_d[0];
            default: sout_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
    end

    // NOTE: SHREG is a visible output, not a storage array, so it is reset
    // along with the control flops.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            bit_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.SOUT  = sout_q;
    assign bus.READY = ready_q;
    assign bus.DONE  = done_q;
    assign bus.SHREG = shreg_q;

endmodule

// File: tb/tb_serial_out_port.sv
// Randomised and directed bench for serial_out_port at BIT_CYCLES 4 and 1,
// compared every cycle against a frame-position reference model.
module tb_serial_out_port;
    import serial_out_port_pkg::*;

    localparam int BC_A  = 4;
    localparam int BC_B  = 1;
    localparam int FRAME = 10;

    logic CLK;
    logic nCLR;
    bit   chk_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;

    serial_out_port_if #(.WIDTH(8)) bus_a ();
    serial_out_port_if #(.WIDTH(8)) bus_b ();

    serial_out_port #(.WIDTH(8), .BIT_CYCLES(BC_A)) u_dut_a (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus_a.slave)
    );

    serial_out_port #(.WIDTH(8), .BIT_CYCLES(BC_B)) u_dut_b (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus_b.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: position within the current frame (-1 when idle).
    int         m_t[2]    = '{-1, -1};
    logic [7:0] m_data[2] = '{8'h00, 8'h00};
    bit         m_done[2] = '{1'b0, 1'b0};

    function automatic int bc_of(input int k);
        return (k == 0) ? BC_A : BC_B;
    endfunction

    task automatic model_step(input int k, input logic nlo4, input logic [7:0] wbus);
        m_done[k] = 1'b0;
        if (m_t[k] < 0) begin
            if (!nlo4) begin
                m_t[k]    = 0;
                m_data[k] = wbus;
            end
        end else begin
            m_t[k]++;
            if (m_t[k] == FRAME * bc_of(k)) begin
                m_t[k]    = -1;
                m_done[k] = 1'b1;
            end
        end
    endtask

    // {SOUT, READY, DONE, SHREG}
    function automatic logic [10:0] model_out(input int k);
        int         slot;
        logic [7:0] tmp;
        logic       s;
        if (m_t[k] < 0) return {1'b1, 1'b1, m_done[k], 8'h00};
        slot = m_t[k] / bc_of(k);
        tmp  = (slot == 0) ? m_data[k] : m_data[k] >> (slot - 1);
        if (slot == 0)      s = 1'b0;
        else if (slot <= 8) s = tmp[0];
        else                s = 1'b1;
        return {s, 1'b0, 1'b0, tmp};
    endfunction

    always @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            for (int k = 0; k < 2; k++) begin
                m_t[k]    = -1;
                m_done[k] = 1'b0;
            end
        end else begin
            model_step(0, bus_a.nLo4, bus_a.WBUS);
            model_step(1, bus_b.nLo4, bus_b.WBUS);
        end
    end

    logic [10:0] act_a, act_b;
    assign act_a = {bus_a.SOUT, bus_a.READY, bus_a.DONE, bus_a.SHREG};
    assign act_b = {bus_b.SOUT, bus_b.READY, bus_b.DONE, bus_b.SHREG};

    always @(negedge CLK) begin
        cyc++;
        if (chk_en) begin
            check($sformatf("cyc%0d bc4 {sout,ready,done,shreg}", cyc), 32'(act_a), 32'(model_out(0)));
            check($sformatf("cyc%0d bc1 {sout,ready,done,shreg}", cyc), 32'(act_b), 32'(model_out(1)));
        end
    end

    // One frame on the BIT_CYCLES=4 port; optionally a second load while busy.
    task automatic send_a(input logic [7:0] d, input int busy_at, input logic [7:0] busy_d,
                          output int done_lat, output int ready_low, output int dones,
                          output logic [7:0] rx);
        done_lat  = -1;
        ready_low = 0;
        dones     = 0;
        rx        = 8'h00;
        bus_a.WBUS = d;
        bus_a.nLo4 = 1'b0;
        tick();
        bus_a.nLo4 = 1'b1;
        bus_a.WBUS = 8'($urandom);
        for (int j = 0; j <= 60; j++) begin
            if (!bus_a.READY) ready_low++;
            if (bus_a.DONE) begin
                dones++;
                if (done_lat < 0) done_lat = j;
            end
            if (j >= BC_A && j < 9 * BC_A && (j % BC_A) == BC_A / 2) rx = {bus_a.SOUT, rx[7:1]};
            if (j == busy_at) begin
                bus_a.WBUS = busy_d;
                bus_a.nLo4 = 1'b0;
            end else begin
                bus_a.nLo4 = 1'b1;
            end
            tick();
        end
    endtask

    int         lat, rlow, dn, gap;
    logic [7:0] rx, rx2;
    logic [9:0] seq;

    initial begin
        nCLR       = 1'b1;
        bus_a.nLo4 = 1'b1;
        bus_a.WBUS = 8'h00;
        bus_b.nLo4 = 1'b1;
        bus_b.WBUS = 8'h00;

        // Reset asserted between edges: outputs must settle without a clock.
        #3 nCLR = 1'b0;
        #1;
        check("reset sout",  32'(bus_a.SOUT),  32'd1);
        check("reset ready", 32'(bus_a.READY), 32'd1);
        check("reset done",  32'(bus_a.DONE),  32'd0);
        check("reset shreg", 32'(bus_a.SHREG), 32'(ZERO_STATE));
        check("reset bc1",   32'(act_b),       32'h600);
        chk_en = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #3 nCLR = 1'b1;
        tick();

        // Single frame, 8'hA5.
        send_a(8'hA5, -1, 8'h00, lat, rlow, dn, rx);
        check("A5 done latency", 32'(lat),  32'(FRAME * BC_A));
        check("A5 ready low",    32'(rlow), 32'(FRAME * BC_A));
        check("A5 done pulses",  32'(dn),   32'd1);
        check("A5 data bits",    32'(rx),   32'h0A5);

        // Second load while busy must be ignored.
        send_a(8'h0F, 10, 8'hF0, lat, rlow, dn, rx);
        check("busy data bits",   32'(rx),  32'h00F);
        check("busy done pulses", 32'(dn),  32'd1);
        check("busy done lat",    32'(lat), 32'(FRAME * BC_A));

        // Back-to-back: nLo4 held low across two frames.
        dn = 0; gap = 0; rx = 8'h00; rx2 = 8'h00;
        bus_a.WBUS = 8'h3C;
        bus_a.nLo4 = 1'b0;
        tick();
        for (int j = 0; j <= 100; j++) begin
            if (bus_a.DONE) dn++;
            if (j >= 1 && j <= 2 * FRAME * BC_A && bus_a.READY) gap++;
            if (j >= 4 && j < 36 && (j % 4) == 2) rx = {bus_a.SOUT, rx[7:1]};
            if (j >= 45 && j < 77 && ((j - 41) % 4) == 2) rx2 = {bus_a.SOUT, rx2[7:1]};
            if (j == 1)  bus_a.WBUS = 8'hC3;
            if (j == 50) bus_a.nLo4 = 1'b1;
            tick();
        end
        check("b2b done pulses",  32'(dn),  32'd2);
        check("b2b idle gap",     32'(gap), 32'd1);
        check("b2b frame1 bits",  32'(rx),  32'h03C);
        check("b2b frame2 bits",  32'(rx2), 32'h0C3);

        // BIT_CYCLES = 1: one clock per bit, no bubbles.
        seq = '0; lat = -1;
        bus_b.WBUS = 8'h81;
        bus_b.nLo4 = 1'b0;
        tick();
        bus_b.nLo4 = 1'b1;
        for (int j = 0; j <= 15; j++) begin
            if (j < 10) seq = {bus_b.SOUT, seq[9:1]};
            if (bus_b.DONE && lat < 0) lat = j;
            tick();
        end
        check("bc1 sout sequence", 32'(seq), 32'({1'b1, 8'h81, 1'b0}));
        check("bc1 done clock",    32'(lat), 32'd10);

        // Mid-frame reset aborts immediately; next load transmits normally.
        bus_a.WBUS = 8'h55;
        bus_a.nLo4 = 1'b0;
        tick();
        bus_a.nLo4 = 1'b1;
        repeat (14) tick();
        #2 nCLR = 1'b0;
        #1;
        check("abort sout",  32'(bus_a.SOUT),  32'd1);
        check("abort ready", 32'(bus_a.READY), 32'd1);
        check("abort done",  32'(bus_a.DONE),  32'd0);
        check("abort shreg", 32'(bus_a.SHREG), 32'd0);
        tick();
        tick();
        #2 nCLR = 1'b1;
        tick();
        send_a(8'h01, -1, 8'h00, lat, rlow, dn, rx);
        check("post-reset bits",    32'(rx),  32'h001);
        check("post-reset latency", 32'(lat), 32'(FRAME * BC_A));
        check("post-reset dones",   32'(dn),  32'd1);

        // Random loads on both ports, with one asynchronous reset pulse.
        for (int i = 0; i < 600; i++) begin
            bus_a.nLo4 = ($urandom_range(0, 7) != 0);
            bus_a.WBUS = 8'($urandom);
            bus_b.nLo4 = ($urandom_range(0, 3) != 0);
            bus_b.WBUS = 8'($urandom);
            if (i == 300) begin
                #2 nCLR = 1'b0;
                #4 nCLR = 1'b1;
            end
            tick();
        end
        bus_a.nLo4 = 1'b1;
        bus_b.nLo4 = 1'b1;
        repeat (50) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
